// File: rtl/mac_phase_sequencer.sv
// Initiator for the LOAD -> COMPUTE -> DRAIN counter handshake of the systolic MAC datapath.
// Runs num_tiles tiles through the three phase counters, with a per-phase watchdog and sticky error.
module mac_phase_sequencer #(
  parameter int TILE_W      = 8,
  parameter int TIMEOUT_W   = 10,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic              abort,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        phase,
  output logic [TILE_W-1:0] tile_idx,
  output logic              load_en,
  output logic              comp_en,
  output logic              drain_en,
  input  logic              load_done,
  input  logic              comp_done,
  input  logic              drain_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_COMP,
    S_DRAIN,
    S_DONE,
    S_ERROR
  } state_e;

  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  state_e               state_q, state_d;
  logic [TILE_W-1:0]    tile_q, tile_d;
  logic [TILE_W-1:0]    count_q, count_d;
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 err_q, err_d;

  logic              phase_done;
  logic              stray;
  logic [TILE_W:0]   tile_next;
  logic              last_tile;

  // A done pulse only counts for the phase that is currently enabled; any other is stray.
  assign phase_done = (state_q == S_LOAD  && load_done) ||
                      (state_q == S_COMP  && comp_done) ||
                      (state_q == S_DRAIN && drain_done);
  assign stray      = (load_done  && state_q != S_LOAD) ||
                      (comp_done  && state_q != S_COMP) ||
                      (drain_done && state_q != S_DRAIN);

  // Extra bit keeps the last-tile compare exact at count = 2**TILE_W-1.
  assign tile_next  = {1'b0, tile_q} + (TILE_W + 1)'(1);
  assign last_tile  = (tile_next == {1'b0, count_q});

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the case leaves it unassigned (no latches).
    state_d = state_q;
    tile_d  = tile_q;
    count_d = count_q;
    wdog_d  = wdog_q;
    err_d   = err_q;

    if (abort) begin
      state_d = S_IDLE;
      wdog_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            count_d = num_tiles;
            tile_d  = '0;
            wdog_d  = '0;
            err_d   = 1'b0;
            state_d = (num_tiles == '0) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD, S_COMP, S_DRAIN: begin
          if (phase_done) begin
            wdog_d = '0;
            unique case (state_q)
              S_LOAD:  state_d = S_COMP;
              S_COMP:  state_d = S_DRAIN;
              default: begin
                if (last_tile) begin
                  state_d = S_DONE;
                end else begin
                  tile_d  = tile_next[TILE_W-1:0];
                  state_d = S_LOAD;
                end
              end
            endcase
          end else if (wdog_q == WDOG_LAST) begin
            wdog_d  = '0;
            err_d   = 1'b1;
            state_d = S_ERROR;
          end else begin
            wdog_d = wdog_q + TIMEOUT_W'(1);
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_IDLE;
      endcase
    end

    // Sticky even over the clear of an accepted start in the same cycle.
    if (stray) err_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      count_q <= '0;
      wdog_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      count_q <= count_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  // Enables drop in the cycle their done arrives, so a counter never takes an extra step.
  assign load_en  = (state_q == S_LOAD)  && !load_done  && !abort;
  assign comp_en  = (state_q == S_COMP)  && !comp_done  && !abort;
  assign drain_en = (state_q == S_DRAIN) && !drain_done && !abort;

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_LOAD) || (state_q == S_COMP) ||
                    (state_q == S_DRAIN) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE) && !abort;
  assign err      = err_q;
  assign tile_idx = tile_q;

  always_comb begin
    phase = 2'd0;
    unique case (state_q)
      S_LOAD:  phase = 2'd1;
      S_COMP:  phase = 2'd2;
      S_DRAIN: phase = 2'd3;
      default: phase = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_mac_phase_sequencer.sv
// Bench for mac_phase_sequencer: three phase counters (limits 4/8/2) plus a per-cycle expected timeline
// built from the tile/phase rules, with hand-computed literals for latencies and enable counts.
module tb_mac_phase_sequencer;

  localparam int TO = 20;

  logic       clk, rst_n, start, abort;
  logic [7:0] num_tiles;
  logic       ready, busy, done, err;
  logic [1:0] phase;
  logic [7:0] tile_idx;
  logic       load_en, comp_en, drain_en;
  logic       load_done, comp_done, drain_done;

  mac_phase_sequencer #(.TILE_W(8), .TIMEOUT_W(10), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .abort(abort),
    .ready(ready), .busy(busy), .done(done), .err(err), .phase(phase), .tile_idx(tile_idx),
    .load_en(load_en), .comp_en(comp_en), .drain_en(drain_en),
    .load_done(load_done), .comp_done(comp_done), .drain_done(drain_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       ready, busy, done, err;
    logic [1:0] phase;
    logic [7:0] tile;
    logic       load_en, comp_en, drain_en;
  } obs_t;

  obs_t obs;
  assign obs = {ready, busy, done, err, phase, tile_idx, load_en, comp_en, drain_en};

  localparam logic [16:0] RESET_OBS = 17'h10000;
  localparam logic [16:0] IDLE_ERR  = 17'h12000;

  // Phase counters: count enabled cycles, pulse done one cycle after the limit-th one.
  logic [3:0] ccnt [3];
  logic [2:0] cdone;
  logic [2:0] en_v;
  logic       stall_comp, inj_drain;
  assign en_v = {drain_en, comp_en, load_en};

  function automatic int lim_of(input int p);
    return (p == 0) ? 4 : (p == 1) ? 8 : 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) ccnt[i] <= '0;
      cdone <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cdone[i] <= 1'b0;
        if (!en_v[i]) ccnt[i] <= '0;
        else if (ccnt[i] == 4'(lim_of(i) - 1)) begin
          ccnt[i]  <= '0;
          cdone[i] <= !(i == 1 && stall_comp);
        end else ccnt[i] <= ccnt[i] + 4'd1;
      end
    end
  end

  assign load_done  = cdone[0];
  assign comp_done  = cdone[1];
  assign drain_done = cdone[2] | inj_drain;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, acc_cyc = 0, last_done_cyc = 0;
  int n_le = 0, n_ce = 0, n_de = 0;
  obs_t exp_q[$];
  logic [7:0] m_tile = '0;
  logic       m_err  = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, got, want);
  endtask

  // Sampled 2 time units before the active edge so inputs driven this cycle are visible.
  always begin
    @(negedge clk);
    #3;
    cyc++;
    if (rst_n && exp_q.size() != 0) begin
      obs_t e;
      e = exp_q.pop_front();
      check("cycle", 32'(obs), 32'(e));
    end
    if (load_en)  n_le++;
    if (comp_en)  n_ce++;
    if (drain_en) n_de++;
    if (done)     last_done_cyc = cyc;
  end

  function automatic obs_t idle_obs(input logic [7:0] t, input logic e);
    obs_t o;
    o = '0;
    o.ready = 1'b1;
    o.tile  = t;
    o.err   = e;
    return o;
  endfunction

  // Expected per-cycle timeline: entry 0 is the accepting IDLE cycle, entry k the k-th cycle after.
  task automatic plan(input int n, input int abort_k, input int stray_k, input bit stall);
    obs_t tl[$];
    obs_t e;
    bit   stop;
    stop = 1'b0;
    tl.push_back(idle_obs(m_tile, m_err));
    for (int t = 0; t < n && !stop; t++) begin
      for (int p = 0; p < 3 && !stop; p++) begin
        int lim, ncyc;
        lim  = lim_of(p);
        ncyc = (stall && p == 1) ? TO : lim + 1;
        for (int c = 1; c <= ncyc; c++) begin
          bit on;
          on = (stall && p == 1) ? 1'b1 : (c <= lim);
          e = '0;
          e.busy     = 1'b1;
          e.phase    = 2'(p + 1);
          e.tile     = 8'(t);
          e.load_en  = (p == 0) && on;
          e.comp_en  = (p == 1) && on;
          e.drain_en = (p == 2) && on;
          tl.push_back(e);
        end
        if (stall && p == 1) begin
          e = '0;
          e.tile = 8'(t);
          e.err  = 1'b1;
          repeat (3) tl.push_back(e);
          stop = 1'b1;
        end
      end
    end
    if (!stop) begin
      e = '0;
      e.busy = 1'b1;
      e.done = 1'b1;
      e.tile = (n == 0) ? 8'd0 : 8'(n - 1);
      tl.push_back(e);
      tl.push_back(idle_obs(e.tile, 1'b0));
    end
    for (int k = 1; k < tl.size(); k++)
      if (stray_k > 0 && k > stray_k) tl[k].err = 1'b1;
    if (abort_k > 0) begin
      tl[abort_k].load_en  = 1'b0;
      tl[abort_k].comp_en  = 1'b0;
      tl[abort_k].drain_en = 1'b0;
      tl[abort_k].done     = 1'b0;
      while (tl.size() > abort_k + 2) void'(tl.pop_back());
      tl[abort_k + 1] = idle_obs(tl[abort_k].tile, tl[abort_k].err);
    end
    m_tile = tl[tl.size() - 1].tile;
    m_err  = tl[tl.size() - 1].err;
    foreach (tl[i]) exp_q.push_back(tl[i]);
  endtask

  // Returns at the drive point of the first cycle after acceptance.
  task automatic issue(input int n, input int abort_k, input int stray_k, input bit stall);
    @(negedge clk);
    #1;
    start     = 1'b1;
    num_tiles = 8'(n);
    acc_cyc   = cyc + 1;
    n_le = 0; n_ce = 0; n_de = 0;
    plan(n, abort_k, stray_k, stall);
    @(negedge clk);
    #1;
    start     = 1'b0;
    num_tiles = 8'hA5;
  endtask

  task automatic wait_q(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #4;
    end
    check("timeline_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_done(input int budget, output int lat);
    for (int i = 0; i < budget && last_done_cyc <= acc_cyc; i++) begin
      @(negedge clk);
      #4;
    end
    lat = (last_done_cyc > acc_cyc) ? last_done_cyc - acc_cyc : -1;
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; num_tiles = '0;
    stall_comp = 1'b0; inj_drain = 1'b0;
    @(negedge clk);
    #3;
    check("reset_values", 32'(obs), 32'(RESET_OBS));
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single tile, 5+9+3 phase cycles then done
    issue(1, 0, 0, 1'b0);
    wait_done(200, lat);
    check("t1_latency", 32'(lat), 32'd18);
    wait_q(50);
    check("t1_en_cycles", {8'(n_le), 8'(n_ce), 8'(n_de)}, {8'd4, 8'd8, 8'd2});

    // 2: three tiles, with a start pulse mid-run that must be ignored
    issue(3, 0, 0, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    start = 1'b1; num_tiles = 8'd5;
    @(negedge clk);
    #1;
    start = 1'b0;
    wait_done(200, lat);
    check("t2_latency", 32'(lat), 32'd52);
    wait_q(50);
    check("t2_en_cycles", {8'(n_le), 8'(n_ce), 8'(n_de)}, {8'd12, 8'd24, 8'd6});

    // 3: zero tiles, done right after acceptance, no enables
    issue(0, 0, 0, 1'b0);
    wait_done(20, lat);
    check("t3_latency", 32'(lat), 32'd1);
    wait_q(20);
    check("t3_no_enables", 32'(n_le + n_ce + n_de), 32'd0);

    // 4: compute never finishes -> watchdog error, then abort
    stall_comp = 1'b1;
    issue(1, 0, 0, 1'b1);
    wait_q(100);
    check("t4_comp_cycles", 32'(n_ce), 32'(TO));
    @(negedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    stall_comp = 1'b0;
    #2;
    check("t4_abort_idle", 32'(obs), 32'(IDLE_ERR));
    @(negedge clk);
    #1;
    start = 1'b1; abort = 1'b1; num_tiles = 8'd2;
    @(negedge clk);
    #1;
    start = 1'b0; abort = 1'b0;
    #2;
    check("t4_abort_beats_start", 32'(obs), 32'(IDLE_ERR));

    // 5: abort in cycle 3 of COMPUTE of tile 1, then a clean run
    issue(2, 25, 0, 1'b0);
    repeat (24) @(negedge clk);
    #1;
    abort = 1'b1;
    @(negedge clk);
    #1;
    abort = 1'b0;
    wait_q(20);
    check("t5_no_done", 32'(last_done_cyc > acc_cyc), 32'd0);
    issue(1, 0, 0, 1'b0);
    wait_done(200, lat);
    check("t5_clean_latency", 32'(lat), 32'd18);
    wait_q(20);

    // 6: stray drain_done in LOAD, then reset in the middle of DRAIN
    issue(1, 0, 2, 1'b0);
    @(negedge clk);
    #1;
    inj_drain = 1'b1;
    @(negedge clk);
    #1;
    inj_drain = 1'b0;
    #2;
    check("t6_stray_err_load", {29'd0, err, phase}, 32'b101);
    repeat (13) @(negedge clk);
    #1;
    check("t6_drain_active", {30'd0, phase == 2'd3, drain_en}, 32'b11);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("t6_reset_mid", 32'(obs), 32'(RESET_OBS));
    @(negedge clk);
    #1;
    rst_n  = 1'b1;
    m_tile = '0;
    m_err  = 1'b0;
    issue(2, 0, 0, 1'b0);
    wait_done(200, lat);
    check("t6_after_reset_latency", 32'(lat), 32'd35);
    wait_q(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
